sdram_req_gen: RTL and testbench

SDRAM_REQ_GEN -- requirements
Module: sdram_req_gen

---
 rtl/sdram_pkg.sv | 19 +
 rtl/sdram_req_chan.sv | 102 ++++++++++
 rtl/sdram_req_gen.sv | 141 ++++++++++++++
 tb/tb_sdram_req_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_pkg
// Brief    : Shared state encoding and default burst geometry for the SDRAM
//            request generator.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_pkg;

  localparam int unsigned c_burst_len    = 512;
  localparam int unsigned c_frame_bursts = 600;

  localparam int unsigned c_st_w    = 2;
  localparam logic [1:0]  c_st_idle = 2'd0;
  localparam logic [1:0]  c_st_req  = 2'd1;
  localparam logic [1:0]  c_st_gap  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sdram_req_chan.sv
`default_nettype none
// ============================================================================
// Module   : sdram_req_chan
// Brief    : One burst-request channel: IDLE/REQ/GAP FSM, burst address,
//            burst counter and deferred frame alignment.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_req_chan
  import sdram_pkg::*;
#(
  parameter int unsigned BURST_LEN    = c_burst_len,
  parameter int unsigned FRAME_BURSTS = c_frame_bursts,
  parameter int unsigned ADDR_W       = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ack,
  input  logic              frame_start,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic              frame_end
);

  localparam int unsigned       c_cnt_w     = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam int unsigned       c_last_i    = FRAME_BURSTS - 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_last_i[c_cnt_w-1:0];
  localparam logic [ADDR_W-1:0]  c_step     = BURST_LEN[ADDR_W-1:0];

  logic [c_st_w-1:0]  r_state;
  logic [c_st_w-1:0]  w_state_nxt;
  logic               r_req;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               r_pend;
  logic               w_pend_nxt;
  logic               w_frame_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == c_st_req);
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (start) w_state_nxt = c_st_req;
      c_st_req:  if (ack)   w_state_nxt = c_st_gap;
      c_st_gap:  w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  // A frame_start seen during REQ is parked and applied on that request's ack
  always_comb begin
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_frame_end = 1'b0;
    if (r_state == c_st_req) begin
      if (ack) begin
        w_pend_nxt = 1'b0;
        if (r_pend || frame_start) begin
          w_addr_nxt = '0;
          w_cnt_nxt  = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_addr_nxt  = '0;
          w_cnt_nxt   = '0;
          w_frame_end = 1'b1;
        end else begin
          w_addr_nxt = r_addr + c_step;
          w_cnt_nxt  = r_cnt + c_cnt_w'(1);
        end
      end else if (frame_start) begin
        w_pend_nxt = 1'b1;
      end
    end else if (frame_start) begin
      w_addr_nxt = '0;
      w_cnt_nxt  = '0;
      w_pend_nxt = 1'b0;
    end
  end

  assign req       = r_req;
  assign addr      = r_addr;
  assign frame_end = w_frame_end;

endmodule
`default_nettype wire

// File: rtl/sdram_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : sdram_req_gen
// Brief    : Camera-write / display-read SDRAM burst request generator with
//            double-buffered frame bank selection. Optional request watchdog
//            enabled by macro SDRAM_REQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_req_gen
  import sdram_pkg::*;
#(
  parameter int unsigned BURST_LEN    = c_burst_len,
  parameter int unsigned FRAME_BURSTS = c_frame_bursts,
  parameter int unsigned LVL_W        = 10,
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LVL_W-1:0]  wr_fifo_rdusedw,
  input  logic [LVL_W-1:0]  rd_fifo_wrusedw,
  input  logic              wr_frame_start,
  input  logic              rd_frame_start,
  input  logic              wr_sdram_ack,
  input  logic              rd_sdram_ack,
  output logic              wr_sdram_req,
  output logic              rd_sdram_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              wr_frame_done
`ifdef SDRAM_REQ_TIMEOUT_EN
  ,
  output logic              req_timeout
`endif
);

  localparam logic [LVL_W:0] c_burst_lvl = BURST_LEN[LVL_W:0];

  logic w_wr_start;
  logic w_rd_start;
  logic w_wr_frame_end;
  logic w_rd_frame_end;
  logic r_wr_bank;
  logic r_rd_bank;
  logic r_last_full;
  logic r_wr_frame_done;

  assign w_wr_start = ({1'b0, wr_fifo_rdusedw} >= c_burst_lvl);
  assign w_rd_start = ({1'b0, rd_fifo_wrusedw} <  c_burst_lvl);

  generate
    if (TIMEOUT < 2) begin : g_chk_timeout
      $error("TIMEOUT must be at least 2");
    end
  endgenerate

  sdram_req_chan #(
    .BURST_LEN    (BURST_LEN),
    .FRAME_BURSTS (FRAME_BURSTS),
    .ADDR_W       (ADDR_W)
  ) u_wr_chan (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (w_wr_start),
    .ack         (wr_sdram_ack),
    .frame_start (wr_frame_start),
    .req         (wr_sdram_req),
    .addr        (wr_addr),
    .frame_end   (w_wr_frame_end)
  );

  sdram_req_chan #(
    .BURST_LEN    (BURST_LEN),
    .FRAME_BURSTS (FRAME_BURSTS),
    .ADDR_W       (ADDR_W)
  ) u_rd_chan (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (w_rd_start),
    .ack         (rd_sdram_ack),
    .frame_start (rd_frame_start),
    .req         (rd_sdram_req),
    .addr        (rd_addr),
    .frame_end   (w_rd_frame_end)
  );

  // Reader follows the newest completed bank; nonblocking order means a
  // same-cycle write completion is only visible to the next read frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_bank       <= 1'b0;
      r_rd_bank       <= 1'b0;
      r_last_full     <= 1'b0;
      r_wr_frame_done <= 1'b0;
    end else begin
      r_wr_frame_done <= w_wr_frame_end;
      if (w_wr_frame_end) begin
        r_wr_bank   <= ~r_wr_bank;
        r_last_full <= r_wr_bank;
      end
      if (w_rd_frame_end) begin
        r_rd_bank <= r_last_full;
      end
    end
  end

  assign wr_bank       = r_wr_bank;
  assign rd_bank       = r_rd_bank;
  assign wr_frame_done = r_wr_frame_done;

`ifdef SDRAM_REQ_TIMEOUT_EN
  localparam int unsigned       c_to_w    = $clog2(TIMEOUT + 1);
  localparam int unsigned       c_to_li   = TIMEOUT - 1;
  localparam logic [c_to_w-1:0] c_to_last = c_to_li[c_to_w-1:0];

  logic [c_to_w-1:0] r_wr_to_cnt;
  logic [c_to_w-1:0] r_rd_to_cnt;
  logic              r_req_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_to_cnt   <= '0;
      r_rd_to_cnt   <= '0;
      r_req_timeout <= 1'b0;
    end else begin
      r_wr_to_cnt <= wr_sdram_req ? r_wr_to_cnt + c_to_w'(1) : '0;
      r_rd_to_cnt <= rd_sdram_req ? r_rd_to_cnt + c_to_w'(1) : '0;
      if ((wr_sdram_req && (r_wr_to_cnt == c_to_last)) ||
          (rd_sdram_req && (r_rd_to_cnt == c_to_last))) begin
        r_req_timeout <= 1'b1;
      end
    end
  end

  assign req_timeout = r_req_timeout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_req_gen
// Brief    : Directed, table-driven self-checking bench for sdram_req_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_req_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  wr_lvl;
  logic [9:0]  rd_lvl;
  logic        wr_fs;
  logic        rd_fs;
  logic        wr_ack;
  logic        rd_ack;
  logic        wr_req;
  logic        rd_req;
  logic [19:0] wr_addr;
  logic [19:0] rd_addr;
  logic        wr_bank;
  logic        rd_bank;
  logic        wr_done;
`ifdef SDRAM_REQ_TIMEOUT_EN
  logic        req_timeout;
`endif

  int n_cmp    = 0;
  int n_bad    = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  sdram_req_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_fifo_rdusedw (wr_lvl),
    .rd_fifo_wrusedw (rd_lvl),
    .wr_frame_start  (wr_fs),
    .rd_frame_start  (rd_fs),
    .wr_sdram_ack    (wr_ack),
    .rd_sdram_ack    (rd_ack),
    .wr_sdram_req    (wr_req),
    .rd_sdram_req    (rd_req),
    .wr_addr         (wr_addr),
    .rd_addr         (rd_addr),
    .wr_bank         (wr_bank),
    .rd_bank         (rd_bank),
    .wr_frame_done   (wr_done)
`ifdef SDRAM_REQ_TIMEOUT_EN
    ,
    .req_timeout     (req_timeout)
`endif
  );

  always @(negedge clk) if (wr_done) done_cnt++;

  typedef struct {
    logic [9:0]  wl;
    logic [9:0]  rl;
    logic        wa;
    logic        ra;
    logic        wf;
    logic        rf;
    logic        ewq;
    logic        erq;
    logic [19:0] ewa;
    logic [19:0] era;
  } vec_t;

  vec_t tbl [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    wr_lvl = 10'd0;
    rd_lvl = 10'd1000;
    wr_fs  = 1'b0;
    rd_fs  = 1'b0;
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_wr_req();
    for (int i = 0; i < 8 && !wr_req; i++) tick();
    chk("wr_req_rise", wr_req, 1);
  endtask

  task automatic wait_rd_req();
    for (int i = 0; i < 8 && !rd_req; i++) tick();
    chk("rd_req_rise", rd_req, 1);
  endtask

  task automatic wr_burst();
    wait_wr_req();
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
  endtask

  task automatic rd_burst();
    wait_rd_req();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
  endtask

  initial begin
    //            wl     rl      wa ra wf rf  ewq erq  ewa      era
    tbl[0]  = '{10'd0,   10'd1000, 0, 0, 0, 0, 0, 0, 20'd0,    20'd0};
    tbl[1]  = '{10'd512, 10'd1000, 0, 0, 0, 0, 1, 0, 20'd0,    20'd0};
    tbl[2]  = '{10'd512, 10'd1000, 0, 0, 0, 0, 1, 0, 20'd0,    20'd0};
    tbl[3]  = '{10'd512, 10'd1000, 1, 0, 0, 0, 0, 0, 20'd512,  20'd0};
    tbl[4]  = '{10'd512, 10'd1000, 0, 0, 0, 0, 0, 0, 20'd512,  20'd0};
    tbl[5]  = '{10'd512, 10'd1000, 0, 0, 0, 0, 1, 0, 20'd512,  20'd0};
    tbl[6]  = '{10'd0,   10'd1000, 0, 1, 0, 0, 1, 0, 20'd512,  20'd0};
    tbl[7]  = '{10'd0,   10'd1000, 1, 0, 0, 0, 0, 0, 20'd1024, 20'd0};
    tbl[8]  = '{10'd0,   10'd1000, 1, 0, 0, 0, 0, 0, 20'd1024, 20'd0};
    tbl[9]  = '{10'd0,   10'd1000, 0, 0, 1, 0, 0, 0, 20'd0,    20'd0};
    tbl[10] = '{10'd0,   10'd511,  0, 0, 0, 0, 0, 1, 20'd0,    20'd0};
    tbl[11] = '{10'd512, 10'd511,  0, 0, 0, 0, 1, 1, 20'd0,    20'd0};
    tbl[12] = '{10'd512, 10'd511,  1, 1, 0, 0, 0, 0, 20'd512,  20'd512};
    tbl[13] = '{10'd0,   10'd1000, 0, 0, 0, 0, 0, 0, 20'd512,  20'd512};

    // Reset state
    do_reset();
    chk("rst wr_req", wr_req, 0);
    chk("rst rd_req", rd_req, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst rd_addr", rd_addr, 0);
    chk("rst wr_bank", wr_bank, 0);
    chk("rst rd_bank", rd_bank, 0);
    chk("rst wr_frame_done", wr_done, 0);
`ifdef SDRAM_REQ_TIMEOUT_EN
    chk("rst req_timeout", req_timeout, 0);
`endif

    // Table-driven cycle vectors
    for (int i = 0; i < 14; i++) begin
      wr_lvl = tbl[i].wl;
      rd_lvl = tbl[i].rl;
      wr_ack = tbl[i].wa;
      rd_ack = tbl[i].ra;
      wr_fs  = tbl[i].wf;
      rd_fs  = tbl[i].rf;
      tick();
      chk($sformatf("vec%0d wr_req", i), wr_req, tbl[i].ewq);
      chk($sformatf("vec%0d rd_req", i), rd_req, tbl[i].erq);
      chk($sformatf("vec%0d wr_addr", i), wr_addr, tbl[i].ewa);
      chk($sformatf("vec%0d rd_addr", i), rd_addr, tbl[i].era);
    end
    wr_ack = 1'b0;
    rd_ack = 1'b0;

    // Ack 20 cycles after req; re-assertion exactly 2 cycles after ack
    do_reset();
    wr_lvl = 10'd512;
    tick();
    chk("lat wr_req up", wr_req, 1);
    repeat (19) tick();
    chk("lat wr_req held", wr_req, 1);
    chk("lat wr_addr held", wr_addr, 0);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("lat wr_req drop", wr_req, 0);
    chk("lat wr_addr step", wr_addr, 512);
    tick();
    chk("lat gap req", wr_req, 0);
    tick();
    chk("lat req re-rise", wr_req, 1);

    // Two full write frames interleaved with two read frames
    do_reset();
    wr_lvl = 10'd512;
    for (int i = 0; i < 599; i++) wr_burst();
    chk("f1 wr_addr 599", wr_addr, 306688);
    chk("f1 wr_bank pre", wr_bank, 0);
    chk("f1 done pre", done_cnt, 0);
    wr_burst();
    wr_lvl = 10'd0;
    chk("f1 wr_addr wrap", wr_addr, 0);
    chk("f1 wr_bank", wr_bank, 1);
    chk("f1 done pulse", wr_done, 1);
    tick();
    chk("f1 done low", wr_done, 0);
    chk("f1 done count", done_cnt, 1);
    rd_lvl = 10'd0;
    for (int i = 0; i < 600; i++) rd_burst();
    rd_lvl = 10'd1000;
    chk("f1 rd_addr wrap", rd_addr, 0);
    chk("f1 rd_bank", rd_bank, 0);
    wr_lvl = 10'd512;
    for (int i = 0; i < 600; i++) wr_burst();
    wr_lvl = 10'd0;
    chk("f2 wr_bank", wr_bank, 0);
    tick();
    tick();
    chk("f2 done count", done_cnt, 2);
    rd_lvl = 10'd0;
    for (int i = 0; i < 599; i++) rd_burst();
    chk("f2 rd_addr 599", rd_addr, 306688);
    chk("f2 rd_bank pre", rd_bank, 0);
    rd_burst();
    rd_lvl = 10'd1000;
    chk("f2 rd_bank", rd_bank, 1);
    chk("f2 rd_addr wrap", rd_addr, 0);

    // Frame align during read REQ is deferred to the ack
    do_reset();
    rd_lvl = 10'd0;
    for (int i = 0; i < 10; i++) rd_burst();
    wait_rd_req();
    chk("align rd_addr pre", rd_addr, 5120);
    rd_fs = 1'b1;
    tick();
    rd_fs = 1'b0;
    chk("align rd_req held", rd_req, 1);
    chk("align rd_addr held", rd_addr, 5120);
    tick();
    tick();
    chk("align rd_addr still", rd_addr, 5120);
    rd_ack = 1'b1;
    rd_lvl = 10'd1000;
    tick();
    rd_ack = 1'b0;
    chk("align rd_addr zero", rd_addr, 0);
    chk("align rd_req drop", rd_req, 0);
    chk("align rd_bank", rd_bank, 0);

    // Reset pulse mid-REQ, with an ack during reset and after it
    do_reset();
    wr_lvl = 10'd512;
    wr_burst();
    wr_burst();
    wait_wr_req();
    chk("mrst wr_addr pre", wr_addr, 1024);
    rst_n  = 1'b0;
    wr_ack = 1'b1;
    tick();
    chk("mrst wr_req", wr_req, 0);
    chk("mrst wr_addr", wr_addr, 0);
    rst_n  = 1'b1;
    wr_lvl = 10'd0;
    tick();
    wr_ack = 1'b0;
    chk("mrst late ack addr", wr_addr, 0);
    chk("mrst late ack req", wr_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
